bitpack_stream_serializer: RTL and testbench

// - Downstream stage of the SimpleBitPack packer.
// - Captures one packed polynomial bitstream (256 coefficients x W_WIDTH bits) and

---
 rtl/bitpack_stream_serializer.sv | 93 +++++++++
 tb/tb_bitpack_stream_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bitpack_stream_serializer.sv
// Serializes one packed polynomial (256 x W_WIDTH bits) into OUT_WIDTH-bit beats, LSB first,
// over a valid/ready stream; a new vector may be loaded on the final beat with no bubble.
module bitpack_stream_serializer #(
    parameter int unsigned W_WIDTH   = 8,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [256*W_WIDTH-1:0]   z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned ZW     = 256 * W_WIDTH;
    localparam int unsigned NBEATS = ZW / OUT_WIDTH;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    if ((ZW % OUT_WIDTH) != 0) begin : g_bad_width
        $error("bitpack_stream_serializer: 256*W_WIDTH must be a multiple of OUT_WIDTH");
    end

    typedef enum logic {StIdle, StSend} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ZW-1:0]    shreg_q, shreg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            shreg_q    <= shreg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        shreg_d    = shreg_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        out_data   = shreg_q[OUT_WIDTH-1:0];

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d    = z;
                    beat_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (beat_cnt_q == LAST_CNT);
                // Upstream may only hand over the next vector as the final beat leaves.
                in_ready  = out_ready && out_last;
                if (out_ready) begin
                    if (out_last) begin
                        beat_cnt_d = '0;
                        if (in_valid) begin
                            shreg_d = z;
                        end else begin
                            // Cleared so out_data reads zero while idle.
                            shreg_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        shreg_d    = shreg_q >> OUT_WIDTH;
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_bitpack_stream_serializer.sv
// Directed bench for bitpack_stream_serializer: full drain, random backpressure, back-to-back
// reload, ignored input mid-polynomial, async reset mid-stream and the single-beat configuration.
module tb_bitpack_stream_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned OW = 32;
    localparam int unsigned ZW = 256 * W;
    localparam int unsigned NB = ZW / OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [ZW-1:0] z;
    logic          out_valid, out_ready, out_last, busy;
    logic [OW-1:0] out_data;

    logic          in_valid_w, in_ready_w, out_valid_w, out_ready_w, out_last_w, busy_w;
    logic [ZW-1:0] out_data_w;

    logic [ZW-1:0] z_a, z_b;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    bitpack_stream_serializer #(.W_WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    bitpack_stream_serializer #(.W_WIDTH(W), .OUT_WIDTH(ZW)) dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .z         (z_a),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .out_data  (out_data_w),
        .out_last  (out_last_w),
        .busy      (busy_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [OW-1:0] beat_of(input logic [ZW-1:0] v, input int k);
        return v[k*OW +: OW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present v for one edge from idle; afterwards beat 0 is on the output.
    task automatic load(input logic [ZW-1:0] v);
        in_valid = 1'b1;
        z        = v;
        #1;
        check("load in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        int cyc;

        for (int j = 0; j < 256; j++) begin
            z_a[j*8 +: 8] = 8'(255 - j);
            z_b[j*8 +: 8] = 8'hA5;
        end

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        z           = '0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b0;
        #3;
        check("rst in_ready",  64'(in_ready),  64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data",  64'(out_data),  64'd0);
        check("rst out_last",  64'(out_last),  64'd0);
        check("rst busy",      64'(busy),      64'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: straight drain
        check("model beat0",  64'(beat_of(z_a, 0)),  64'hFCFDFEFF);
        check("model beat63", 64'(beat_of(z_a, 63)), 64'h00010203);
        load(z_a);
        out_ready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            check("t1 valid", 64'(out_valid), 64'd1);
            check("t1 data",  64'(out_data),  64'(beat_of(z_a, i)));
            check("t1 last",  64'(out_last),  64'(i == NB - 1));
            tick();
        end
        check("t1 idle valid", 64'(out_valid), 64'd0);
        check("t1 idle ready", 64'(in_ready),  64'd1);
        check("t1 idle busy",  64'(busy),      64'd0);

        // 2: random backpressure
        load(z_a);
        k   = 0;
        cyc = 0;
        while (k < NB && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("t2 valid", 64'(out_valid), 64'd1);
            check("t2 data",  64'(out_data),  64'(beat_of(z_a, k)));
            check("t2 last",  64'(out_last),  64'(k == NB - 1));
            if (out_ready) k++;
            tick();
            cyc++;
        end
        check("t2 beats done", 64'(k), 64'(NB));
        check("t2 idle valid", 64'(out_valid), 64'd0);

        // 3: zero-bubble reload on the final beat
        load(z_a);
        out_ready = 1'b1;
        for (int i = 0; i < NB - 1; i++) tick();
        check("t3 last before", 64'(out_last), 64'd1);
        in_valid = 1'b1;
        z        = z_b;
        #1;
        check("t3 in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("t3 valid",    64'(out_valid),      64'd1);
        check("t3 data",     64'(out_data),       64'hA5A5A5A5);
        check("t3 beat_cnt", 64'(dut.beat_cnt_q), 64'd0);
        for (int i = 0; i < NB; i++) begin
            check("t3 data b", 64'(out_data), 64'hA5A5A5A5);
            check("t3 last b", 64'(out_last), 64'(i == NB - 1));
            tick();
        end
        check("t3 idle valid", 64'(out_valid), 64'd0);

        // 4: in_valid held mid-polynomial is ignored
        load(z_a);
        for (int i = 0; i < NB; i++) begin
            in_valid = (i >= 5 && i <= 62);
            z        = z_b;
            #1;
            if (i >= 5 && i <= 62) check("t4 in_ready", 64'(in_ready), 64'd0);
            check("t4 data", 64'(out_data), 64'(beat_of(z_a, i)));
            tick();
        end
        in_valid = 1'b0;
        check("t4 idle valid", 64'(out_valid), 64'd0);

        // 5: async reset mid-polynomial
        load(z_a);
        for (int i = 0; i < 20; i++) tick();
        check("t5 beat20", 64'(out_data), 64'(beat_of(z_a, 20)));
        rst = 1'b1;
        #1;
        check("t5 valid async", 64'(out_valid), 64'd0);
        check("t5 busy async",  64'(busy),      64'd0);
        tick();
        rst = 1'b0;
        load(z_a);
        check("t5 restart beat0", 64'(out_data), 64'hFCFDFEFF);
        tick();
        check("t5 restart beat1", 64'(out_data), 64'(beat_of(z_a, 1)));
        out_ready = 1'b0;

        // 6: single-beat configuration
        in_valid_w = 1'b1;
        #1;
        check("t6 in_ready", 64'(in_ready_w), 64'd1);
        tick();
        in_valid_w = 1'b0;
        check("t6 valid", 64'(out_valid_w), 64'd1);
        check("t6 last",  64'(out_last_w),  64'd1);
        check("t6 data",  64'(out_data_w == z_a), 64'd1);
        check("t6 hold",  64'(out_valid_w), 64'd1);
        out_ready_w = 1'b1;
        tick();
        check("t6 idle valid", 64'(out_valid_w), 64'd0);
        check("t6 idle data",  64'(out_data_w == '0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
